// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative MUL/DIV sequencer.
//   state_t      : sequencer FSM encoding
//   OP_MUL/OP_DIV: operation select encoding
//   DEF_WIDTH/DEF_CNTW: default operand and iteration-counter widths
package muldiv_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNTW  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_iter_datapath.sv
// Shift-add multiply / restoring divide datapath, one iteration per step.
//   clock, reset_ : clock and synchronous active-low reset
//   load          : capture a, b, op and clear the accumulators
//   step          : perform one iteration
//   op            : OP_MUL or OP_DIV (latched on load)
//   a, b          : operands
//   result_c      : product low bits / quotient as they will be after this step
//   remainder_c   : DIV remainder after this step, 0 for MUL
module muldiv_iter_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             load,
    input  logic             step,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_c,
    output logic [WIDTH-1:0] remainder_c
);

    logic             op_q;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] rem, dvd, dvs, quo;

    logic [WIDTH-1:0] acc_step;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // Single-iteration arithmetic. The shifted remainder is kept one bit wider
    // so divisors with the MSB set still compare correctly. With a zero
    // divisor every quotient bit is 1 and the dividend ends up in rem, which
    // yields the required divide-by-zero result without a special case.
    always_comb begin
        acc_step  = mplier[0] ? acc + mcand : acc;
        rem_shift = {rem, dvd[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs});
        rem_step  = rem_ge ? (rem_shift[WIDTH-1:0] - dvs) : rem_shift[WIDTH-1:0];
        quo_step  = {quo[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        result_c    = (op_q == OP_DIV) ? quo_step : acc_step;
        remainder_c = (op_q == OP_DIV) ? rem_step : '0;
    end

    // Iteration registers.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            op_q   <= OP_MUL;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            quo    <= '0;
        end else if (load) begin
            op_q   <= op;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            rem    <= '0;
            dvd    <= a;
            dvs    <= b;
            quo    <= '0;
        end else if (step) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_step;
            dvd    <= dvd << 1;
            quo    <= quo_step;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Fixed-latency iterative unsigned MUL/DIV unit for the core ALU.
//   clock, reset_ : clock and synchronous active-low reset
//   start, op     : request and operation select (honoured only in IDLE)
//   a, b          : operands, latched at start
//   busy          : iteration in progress
//   done          : one-cycle pulse, result/remainder valid
//   result        : product low bits or quotient, held until next done/reset
//   remainder     : DIV remainder, 0 after MUL
//   stall         : combinational pipeline hold request to the core
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNTW  = DEF_CNTW
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             stall
);

    state_t           state, state_nxt;
    logic [CNTW-1:0]  cnt;
    logic             load, step;
    logic [WIDTH-1:0] dp_result_c, dp_remainder_c;

    muldiv_iter_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock       (clock),
        .reset_      (reset_),
        .load        (load),
        .step        (step),
        .op          (op),
        .a           (a),
        .b           (b),
        .result_c    (dp_result_c),
        .remainder_c (dp_remainder_c)
    );

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == CNTW'(WIDTH - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The core must hold its PC from the very cycle it raises start.
    always_comb begin
        stall = ((state == ST_IDLE) && start) || busy;
    end

    // State, counter and registered outputs. The last iteration's result is
    // taken straight from the datapath's next value so it lands with done.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_RUN);
            done  <= (state_nxt == ST_DONE);
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + CNTW'(1);
            end
            if (step && (state_nxt == ST_DONE)) begin
                result    <= dp_result_c;
                remainder <= dp_remainder_c;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset_;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done, stall;
    logic [W-1:0] result, remainder;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        int unsigned  cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc   = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    muldiv_sequencer #(
        .WIDTH (W),
        .CNTW  (6)
    ) dut (
        .clock     (clock),
        .reset_    (reset_),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .stall     (stall)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            check("busy_during_done", 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("remainder", 64'(remainder), 64'(e.rem));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Issue one op from an IDLE negedge; start is sampled on the next posedge.
    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic [W-1:0] erm);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        check("stall_on_start", 64'(stall), 64'd1);
        e.res = er;
        e.rem = erm;
        e.cyc = cyc + 1 + W;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Return at the first IDLE negedge once all expectations are consumed.
    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy && !done) return;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned k;
        exp_t        e;

        start  = 1'b0;
        op     = 1'b0;
        a      = '0;
        b      = '0;
        reset_ = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        reset_ = 1'b1;
        @(negedge clock);

        // MUL basics and overflow, with operand changes during RUN
        issue(1'b0, 32'd7, 32'd6, 32'h0000_002A, 32'd0);
        check("busy_after_start", 64'(busy), 64'd1);
        wait_idle();
        issue(1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd0);
        a  = '0;
        b  = '0;
        op = 1'b1;
        wait_idle();

        // DIV, including divide by zero and a divisor with MSB set
        issue(1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
        wait_idle();
        issue(1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
        wait_idle();
        issue(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        wait_idle();
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1);
        wait_idle();
        repeat (3) @(negedge clock);
        check("result_held", 64'(result), 64'd1);
        check("remainder_held", 64'(remainder), 64'd1);

        // Reset at the 10th edge after start: no done, outputs cleared
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd3;
        b     = 32'd9;
        @(negedge clock);
        start = 1'b0;
        check("busy_pre_reset", 64'(busy), 64'd1);
        repeat (9) @(negedge clock);
        reset_ = 1'b0;
        @(negedge clock);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_remainder", 64'(remainder), 64'd0);
        reset_ = 1'b1;
        repeat (40) @(negedge clock);
        issue(1'b0, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'd0);
        wait_idle();

        // start held through RUN and DONE: first op, then one restart from IDLE
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd3;
        b     = 32'd5;
        k     = cyc + 1;
        e.res = 32'd15;
        e.rem = 32'd0;
        e.cyc = k + W;
        sb.push_back(e);
        e.cyc = k + W + 2 + W;
        sb.push_back(e);
        repeat (W + 3) @(negedge clock);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle iterative sequencer for unsigned MUL and DIV. It replaces the single-cycle `*` and `/` paths in the core ALU. The core raises `start` while a MUL/DIV instruction is current and holds its PC from `stall`. The block owns an internal shift-add / restoring-divide datapath and returns the result after a fixed latency.

Parameters:
WIDTH, 32, operand/result width in bits
CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH

Ports:
clock  input  1  system clock, all state updates on posedge
reset_  input  1  synchronous active-low reset, sampled on posedge clock
start  input  1  request: begin operation on a/b (honoured only in IDLE)
op  input  1  0 = MUL (low WIDTH bits of a*b), 1 = DIV (a/b unsigned)
a  input  WIDTH  operand A (multiplicand / dividend)
b  input  WIDTH  operand B (multiplier / divisor)
busy  output  1  iteration in progress
done  output  1  one-cycle pulse, result/remainder valid
result  output  WIDTH  product low bits, or quotient
remainder  output  WIDTH  DIV remainder; 0 after MUL
stall  output  1  combinational: (state==IDLE & start) | busy; core holds PC while high

Behaviour:
- Reset: reset_ low at a posedge forces IDLE, counter 0, result 0, remainder 0. busy, done and stall stay 0 until start is seen. This applies in any state, including mid-iteration; any partial result is discarded.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at a posedge latches a, b, op, clears the accumulators and counter, and goes to RUN. start=0 stays in IDLE.
  - RUN: busy=1. One iteration per cycle; counter increments. After exactly WIDTH iterations, go to DONE.
  - DONE: done=1, busy=0, stall=0, so the core advances its PC on this edge. Next state is IDLE unconditionally.
- Latency: start sampled at edge 0. busy is high for cycles 1..WIDTH. done is high in cycle WIDTH+1. With WIDTH=32, done is seen 33 cycles after start. Latency is identical for both ops and for all operand values.
- start in RUN or DONE is ignored. A back-to-back MUL/DIV re-asserts start in the following IDLE cycle.
- Operands are latched at start; a, b and op changes during RUN have no effect.
- MUL iteration:
  - if mplier[0], acc += mcand (WIDTH bits, carry discarded)
  - mcand <<= 1; mplier >>= 1
  - result = acc truncated to WIDTH; remainder = 0
- DIV iteration (restoring):
  - rem = {rem[WIDTH-2:0], dividend MSB}; dividend <<= 1
  - if rem >= divisor: rem -= divisor, quotient bit = 1; else quotient bit = 0
  - the comparison uses a WIDTH+1-bit subtract
- Divide by zero (b==0, detected at start): result = all ones, remainder = a. Full latency is still taken and done pulses normally.
- result and remainder update only on entry to DONE. They are held through IDLE until the next DONE or reset.
- done is a single-cycle pulse and is never asserted with busy.

Decomposition:
- Shared package muldiv_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - op constants OP_MUL=1'b0, OP_DIV=1'b1
  - default WIDTH
- One sub-module, muldiv_iter_datapath:
  - holds the acc/mcand/mplier and rem/dividend/quotient registers
  - inputs: load, step, op
  - outputs: the final values
- muldiv_sequencer keeps the FSM, counter, stall/done logic and output registers.

Test Plan:
1. MUL 7*6: start=1, op=0, a=7, b=6 for one cycle → stall=1 that cycle; busy=1 for 32 cycles; done=1 at cycle 33 with result=0x0000002A, remainder=0.
2. MUL overflow 0xFFFFFFFF*2 → result=0xFFFFFFFE at cycle 33. Also drive a=0, b=0 during RUN → result unchanged.
3. DIV 100/7: op=1 → result=14 (0x0E), remainder=2 at cycle 33. Then DIV 0x80000000/1 → result=0x80000000, remainder=0.
4. DIV by zero 5/0 → result=0xFFFFFFFF, remainder=5, done still at cycle 33 after start.
5. Reset mid-operation: start MUL at cycle 0, reset_=0 at cycle 10 edge → busy=0, done=0, result=0 from cycle 11. No done pulse occurs. A new start afterwards completes normally in 33 cycles.
6. Start held continuously through RUN and DONE → no restart. Exactly one done pulse, then IDLE accepts start again and the second done appears 33 cycles after that edge.
